mux32_rr_arbiter: RTL and testbench
===================================

# mux32_rr_arbiter

Round-robin arbiter and select sequencer for the 32-to-1 16-bit mux. It shares the mux output among 32 requesters and drives the mux's 5-bit select. Each winner is held for a bounded burst of accepted beats, then the grant rotates. It sits between the requester bank and the mux select pins.

## Interface
Parameters:
- N_REQ, 32, number of requesters (mux inputs); fixed at 32 for this mux.
- SEL_W, 5, select width, equal to log2(N_REQ).
- MAX_BURST, 4, maximum accepted beats per grant (1..15).

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N_REQ  per-requester request level; a requester holds it high while it has data.
- out_ready  input  1  downstream accepts the mux output this cycle.
- grant  output  N_REQ  one-hot grant, registered; all zero when idle.
- sel  output  SEL_W  mux select (s4..s0 order, sel[0] = s0), registered; holds the last value when idle.
- sel_valid  output  1  registered; high while a grant is active.
- beat_last  output  1  combinational; high on the accepted beat that ends the current grant.

## Operation
- States: IDLE, GRANT. Reset state is IDLE.
- A beat is accepted when sel_valid, out_ready and req[sel] are all high.
- IDLE:
  - If any req bit is high, pick the first set bit scanning upward from ptr, wrapping 31 to 0.
  - Load sel with that index, set grant to its one-hot, set sel_valid, clear beat_cnt, go to GRANT.
  - If no req bit is high, stay in IDLE.
- GRANT, each cycle:
  - On an accepted beat, beat_cnt increments.
  - Release when req[sel] is low, or when a beat is accepted and beat_cnt equals MAX_BURST-1. beat_last is high on that accepted beat.
  - On release, the next state is IDLE, grant clears, sel_valid clears, and ptr becomes (sel+1) mod N_REQ.
- Both release conditions in the same cycle count as a single release.
- A requester that drops req mid-burst forfeits the rest of its burst. ptr still advances past it.
- Other requesters' req changes during GRANT are ignored until the next IDLE cycle.
- out_ready low stalls the burst indefinitely. beat_cnt holds and grant holds.
- The MAX_BURST counter uses a 4-bit beat_cnt. There are no unsigned wrap cases, because beat_cnt never exceeds MAX_BURST-1.

## Timing
- Reset (asynchronous, any time, including mid-burst):
  - state=IDLE, grant=0, sel=0, sel_valid=0, ptr=0, beat_cnt=0.
  - beat_last=0, since it is gated by sel_valid.
- First grant is registered 1 cycle after req is sampled in IDLE.
- Arbitration gap: exactly one IDLE cycle between consecutive grants, even when req is continuously asserted.
- Maximum throughput with one requester and out_ready held high: MAX_BURST beats, then 1 idle cycle, repeating.
- sel and grant never change while sel_valid is high.
- The mux output is valid in the same cycle as sel_valid. Mux delay is combinational.

## Structure
- Package mux_arb_pkg holds:
  - the N_REQ, SEL_W and MAX_BURST defaults;
  - the state enum {IDLE, GRANT};
  - the beat counter width constant (4).
- Sub-module rr_priority_pick: purely combinational rotating priority encoder.
  - Inputs: req and ptr.
  - Outputs: any_req, idx[SEL_W-1:0].
  - Implemented as a double-width masked scan.
- The top holds the FSM, ptr, beat_cnt and the output registers.

## Test plan
- Reset/idle: rst_n low then high, req=0 for 5 cycles -> grant=0, sel=0, sel_valid=0 throughout.
- Single full burst: req[7]=1 held, out_ready=1 -> grant=0x00000080, sel=7 one cycle later. Exactly 4 beats accepted, beat_last on the 4th, one IDLE cycle, then regrant to 7.
- Rotation and wrap: req[0], req[2] and req[31] held, out_ready=1 -> grant order is 0, 2, 31, 0, 2, 31. Each grant gets 4 beats with a 1-cycle gap between grants.
- Stall and early drop:
  - req[1] and req[5] held, out_ready=0 for 10 cycles -> sel=1 held, beat_cnt=0, no beat_last.
  - Then out_ready=1 for 2 beats and req[1] dropped -> release without beat_last, next grant sel=5.
- Async reset mid-burst: assert rst_n low during beat 2 of a grant to 12 -> outputs clear immediately without waiting for clk. After release, arbitration restarts from ptr=0.
- Release and new request in the same cycle: req[3] drops while req[4] rises -> one IDLE cycle, then grant=4.

Source files
------------

// File: rtl/mux32_rr_arbiter_pkg.sv
// Shared constants and types for the 32-to-1 mux round-robin arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mux_arb_pkg;

  // Default geometry of the mux this arbiter sequences.
  localparam int N_REQ_DEF     = 32;
  localparam int SEL_W_DEF     = 5;
  localparam int MAX_BURST_DEF = 4;

  // Beat counter width; wide enough for any burst length of 1..15.
  localparam int BEAT_W = 4;

  // Arbiter FSM: waiting to pick a winner, or serving one.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mux32_rr_arbiter_if.sv
// Handshake bundle between the requester bank, the arbiter and the mux select pins.
// Latency: n/a (wires only).
// Backpressure: out_ready from downstream gates beat acceptance.
interface mux32_rr_arbiter_if #(
  parameter int N_REQ = mux_arb_pkg::N_REQ_DEF,
  parameter int SEL_W = mux_arb_pkg::SEL_W_DEF
) ();

  logic [N_REQ-1:0] req;
  logic             out_ready;
  logic [N_REQ-1:0] grant;
  logic [SEL_W-1:0] sel;
  logic             sel_valid;
  logic             beat_last;

  // Arbiter side: owns grant/select, observes requests and downstream ready.
  modport master (
    input  req,
    input  out_ready,
    output grant,
    output sel,
    output sel_valid,
    output beat_last
  );

  // Requester/downstream side.
  modport slave (
    output req,
    output out_ready,
    input  grant,
    input  sel,
    input  sel_valid,
    input  beat_last
  );

endinterface

// File: rtl/mux32_rr_arbiter_pick.sv
// Rotating priority encoder: first set req bit at or above ptr, wrapping to bit 0.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle.
module rr_priority_pick #(
  parameter int N_REQ = mux_arb_pkg::N_REQ_DEF,
  parameter int SEL_W = mux_arb_pkg::SEL_W_DEF
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any_req,
  output logic [SEL_W-1:0] idx
);

  logic [N_REQ-1:0]   upper_mask;
  logic [2*N_REQ-1:0] dbl_req;
  logic [SEL_W-1:0]   pos;

  // Lower half holds only requests at or above ptr, upper half holds all of
  // them, so the lowest set bit of the doubled vector is the wrapped winner.
  // N_REQ is a power of two, so dropping the top position bit folds the
  // upper-half hit back onto its requester index.
  always_comb begin
    upper_mask = {N_REQ{1'b1}} << ptr;
    dbl_req    = {req, req & upper_mask};
    pos        = '0;
    for (int i = 2 * N_REQ - 1; i >= 0; i--) begin
      if (dbl_req[i]) begin
        pos = i[SEL_W-1:0];
      end
    end
  end

  assign any_req = |req;
  assign idx     = pos;

endmodule

// File: rtl/mux32_rr_arbiter.sv
// Round-robin arbiter driving the 5-bit select of the 32:1 mux, bursts capped at MAX_BURST beats.
// Latency: grant registered 1 cycle after req seen in IDLE; one IDLE cycle between grants.
// Backpressure: out_ready low stalls the burst indefinitely; grant and beat count hold.
module mux32_rr_arbiter #(
  parameter int N_REQ     = mux_arb_pkg::N_REQ_DEF,
  parameter int SEL_W     = mux_arb_pkg::SEL_W_DEF,
  parameter int MAX_BURST = mux_arb_pkg::MAX_BURST_DEF
) (
  input logic                clk,
  input logic                rst_n,
  mux32_rr_arbiter_if.master bus
);

  import mux_arb_pkg::*;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST - 1);
  localparam logic [SEL_W-1:0]  TOP_IDX   = SEL_W'(N_REQ - 1);
  localparam logic [N_REQ-1:0]  ONE_HOT0  = {{(N_REQ - 1){1'b0}}, 1'b1};

  arb_state_t        state;
  logic [SEL_W-1:0]  ptr;
  logic [BEAT_W-1:0] beat_cnt;

  logic              any_req;
  logic [SEL_W-1:0]  pick_idx;
  logic              cur_req;
  logic              accept;
  logic              at_last;
  logic              rel_now;
  logic [SEL_W-1:0]  next_ptr;

  rr_priority_pick #(
    .N_REQ (N_REQ),
    .SEL_W (SEL_W)
  ) u_pick (
    .req     (bus.req),
    .ptr     (ptr),
    .any_req (any_req),
    .idx     (pick_idx)
  );

  // Beat acceptance and release qualifiers for the grant currently held.
  // A dropped request and a final beat in the same cycle are one release.
  always_comb begin
    cur_req  = bus.req[bus.sel];
    accept   = bus.sel_valid & bus.out_ready & cur_req;
    at_last  = (beat_cnt == LAST_BEAT);
    rel_now  = bus.sel_valid & (~cur_req | (accept & at_last));
    next_ptr = (bus.sel == TOP_IDX) ? '0 : bus.sel + 1'b1;
  end

  // Only a beat actually accepted can end the grant; a dropped request
  // releases silently. Gated by sel_valid through accept, so low in reset.
  assign bus.beat_last = accept & at_last;

  // Arbitration FSM with registered grant/select outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.grant     <= '0;
      bus.sel       <= '0;
      bus.sel_valid <= 1'b0;
      ptr           <= '0;
      beat_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state         <= GRANT;
            bus.sel       <= pick_idx;
            bus.grant     <= ONE_HOT0 << pick_idx;
            bus.sel_valid <= 1'b1;
            beat_cnt      <= '0;
          end
        end
        GRANT: begin
          if (rel_now) begin
            // sel is left at the old winner so the mux stays put while idle;
            // the pointer moves past it even if it forfeited its burst.
            state         <= IDLE;
            bus.grant     <= '0;
            bus.sel_valid <= 1'b0;
            ptr           <= next_ptr;
          end else if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: begin
          state         <= IDLE;
          bus.grant     <= '0;
          bus.sel_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux32_rr_arbiter.sv
// Randomised and directed check of mux32_rr_arbiter against a cycle-level reference model.
// Latency: model predicts outputs each cycle from req/out_ready history.
// Backpressure: out_ready stalls are driven directly and randomly.
module tb_mux32_rr_arbiter;

  localparam int NR = 32;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mux32_rr_arbiter_if bus ();

  mux32_rr_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: who owns the mux, how many beats it has had, and
  // where the next round-robin scan starts.
  bit m_active;
  int m_owner;
  int m_ptr;
  int m_beats;

  // Observed statistics for directed scenarios.
  int n_acc;
  int n_last;
  int grant_log[$];
  bit prev_valid;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Round-robin choice stated directly: walk indices ptr, ptr+1, ... mod NR.
  function automatic int rr_pick(input logic [31:0] r, input int p);
    for (int k = 0; k < NR; k++) begin
      if (r[(p + k) % NR]) return (p + k) % NR;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_active   = 1'b0;
    m_owner    = 0;
    m_ptr      = 0;
    m_beats    = 0;
    prev_valid = 1'b0;
  endtask

  // Advance the model across one rising edge with the inputs seen there.
  task automatic model_step(input logic [31:0] r, input bit rdy);
    bit acc;
    if (!m_active) begin
      if (r != 32'd0) begin
        m_owner  = rr_pick(r, m_ptr);
        m_active = 1'b1;
        m_beats  = 0;
      end
    end else begin
      acc = rdy && r[m_owner];
      if (!r[m_owner] || (acc && m_beats == MB - 1)) begin
        m_active = 1'b0;
        m_ptr    = (m_owner + 1) % NR;
      end else if (acc) begin
        m_beats++;
      end
    end
  endtask

  // One clock: drive at the falling edge, compare just after, then step.
  task automatic cycle(input logic [31:0] r, input bit rdy);
    logic [31:0] exp_grant;
    bit          exp_last;
    bus.req       = r;
    bus.out_ready = rdy;
    #1;
    exp_grant = m_active ? (32'd1 << m_owner) : 32'd0;
    exp_last  = m_active && rdy && r[m_owner] && (m_beats == MB - 1);
    check("grant", bus.grant, exp_grant);
    check("sel", bus.sel, m_owner);
    check("sel_valid", bus.sel_valid, m_active);
    check("beat_last", bus.beat_last, exp_last);
    if (bus.sel_valid && rdy && r[bus.sel]) n_acc++;
    if (bus.beat_last) n_last++;
    if (bus.sel_valid && !prev_valid) grant_log.push_back(int'(bus.sel));
    prev_valid = bus.sel_valid;
    @(posedge clk);
    model_step(r, rdy);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.req       = '0;
    bus.out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    bit          rdy;
    int          hold;
    int          exp_order[6];

    exp_order = '{0, 2, 31, 0, 2, 31};
    rst_n         = 1'b0;
    bus.req       = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);

    // Reset and idle with no requests.
    do_reset();
    check("rst_grant", bus.grant, 0);
    check("rst_sel", bus.sel, 0);
    check("rst_valid", bus.sel_valid, 0);
    repeat (5) cycle(32'd0, 1'b1);

    // Single requester: exactly MAX_BURST beats, one gap, regrant.
    n_acc  = 0;
    n_last = 0;
    cycle(32'h0000_0080, 1'b1);
    check("burst_grant", bus.grant, 32'h0000_0080);
    check("burst_sel", bus.sel, 7);
    repeat (4) cycle(32'h0000_0080, 1'b1);
    check("burst_beats", n_acc, 4);
    check("burst_last_cnt", n_last, 1);
    check("burst_gap", bus.sel_valid, 0);
    cycle(32'h0000_0080, 1'b1);
    check("burst_regrant_sel", bus.sel, 7);
    check("burst_regrant_vld", bus.sel_valid, 1);

    // Rotation with wrap from 31 back to 0.
    do_reset();
    grant_log.delete();
    repeat (30) cycle(32'h8000_0005, 1'b1);
    check("rot_count", grant_log.size(), 6);
    for (int i = 0; i < 6; i++) begin
      check("rot_order", (i < grant_log.size()) ? grant_log[i] : -1, exp_order[i]);
    end

    // Stall, then early drop of the owner.
    do_reset();
    n_acc  = 0;
    n_last = 0;
    repeat (11) cycle(32'h0000_0022, 1'b0);
    check("stall_sel", bus.sel, 1);
    check("stall_beats", n_acc, 0);
    check("stall_last", n_last, 0);
    repeat (2) cycle(32'h0000_0022, 1'b1);
    check("stall_resume_beats", n_acc, 2);
    cycle(32'h0000_0020, 1'b1);
    check("drop_no_last", n_last, 0);
    check("drop_released", bus.sel_valid, 0);
    cycle(32'h0000_0020, 1'b1);
    check("drop_next_sel", bus.sel, 5);
    check("drop_next_vld", bus.sel_valid, 1);

    // Asynchronous reset during beat 2 of a grant to 12, with ptr away from 0.
    do_reset();
    repeat (5) cycle(32'h0010_0000, 1'b1);
    cycle(32'h0000_1000, 1'b1);
    check("pre_rst_sel", bus.sel, 12);
    cycle(32'h0000_1000, 1'b1);
    bus.req       = 32'h0000_1000;
    bus.out_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_grant", bus.grant, 0);
    check("arst_sel", bus.sel, 0);
    check("arst_valid", bus.sel_valid, 0);
    check("arst_last", bus.beat_last, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(32'h0200_1000, 1'b1);
    check("arst_restart_sel", bus.sel, 12);

    // Owner drops while another requester rises in the same cycle.
    do_reset();
    cycle(32'h0000_0008, 1'b1);
    cycle(32'h0000_0008, 1'b1);
    cycle(32'h0000_0010, 1'b1);
    check("swap_gap", bus.sel_valid, 0);
    cycle(32'h0000_0010, 1'b1);
    check("swap_grant", bus.grant, 32'h0000_0010);

    // Randomised traffic against the model.
    do_reset();
    r    = '0;
    hold = 0;
    for (int n = 0; n < 1500; n++) begin
      if (hold == 0) begin
        case ($urandom_range(0, 3))
          0: r = '0;
          1: r = 32'd1 << $urandom_range(0, 31);
          2: r = $urandom() & $urandom() & $urandom();
          default: r = $urandom();
        endcase
        hold = $urandom_range(1, 8);
      end
      hold--;
      rdy = ($urandom_range(0, 3) != 0);
      cycle(r, rdy);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
